// File: rtl/ss_wbm_arb.sv
// ss_wbm_arb: two-requester Wishbone master arbiter.
// m0 (SG descriptor reader) and m1 (data mover) share one 32/64-bit WB
// master port. Round-robin between requesters; a grant is held for as long
// as its owner keeps cyc asserted, so bursts are never split.
// Optional ack watchdog: define ARB_TIMEOUT_EN to enable it. When the
// macro is undefined, a granted owner waits forever for the slave.
module ss_wbm_arb #(
    parameter int TMO_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic        m0_cab_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m0_dat64_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m0_dat64_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic        m1_cab_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [31:0] m1_dat64_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] m1_dat_o,
    output logic [31:0] m1_dat64_o,

    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic        wbs_cab_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] wbs_dat64_o,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_dat64_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,

    output logic [1:0]  arb_gnt_o
);

    // Encoding doubles as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic [1:0] req;
    logic       tmo_hit;

`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       blk_q, blk_d;
    logic             rsp;

    assign rsp     = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign tmo_hit = (state_q != IDLE) && (&tmo_q);
    // A requester that timed out is ignored until it drops cyc.
    assign req     = {m1_cyc_i, m0_cyc_i} & ~blk_q;

    // Watchdog counter and per-requester lockout after a timeout.
    always_comb begin
        tmo_d = tmo_q;
        blk_d = blk_q;
        if (state_q == IDLE || state_d != state_q || rsp)
            tmo_d = '0;
        else if (wbs_stb_o)
            tmo_d = tmo_q + 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (tmo_hit && state_q[i])
                blk_d[i] = 1'b1;
            else if (!(i == 0 ? m0_cyc_i : m1_cyc_i))
                blk_d[i] = 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign req     = {m1_cyc_i, m0_cyc_i};
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            tmo_q      <= '0;
            blk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
            blk_q      <= blk_d;
`endif
        end
    end

    // Next-state: round-robin in IDLE, hold while owner keeps cyc, hand off on release.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (req[0] && req[1])
                    state_d = last_gnt_q ? GNT0 : GNT1;
                else if (req[0])
                    state_d = GNT0;
                else if (req[1])
                    state_d = GNT1;
            end
            GNT0: begin
                if (tmo_hit) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end else if (!m0_cyc_i) begin
                    last_gnt_d = 1'b0;
                    state_d    = req[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (tmo_hit) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end else if (!m1_cyc_i) begin
                    last_gnt_d = 1'b1;
                    state_d    = req[0] ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux: owner drives the slave port and alone sees the slave response.
    always_comb begin
        wbs_cyc_o   = 1'b0;
        wbs_stb_o   = 1'b0;
        wbs_we_o    = 1'b0;
        wbs_cab_o   = 1'b0;
        wbs_sel_o   = '0;
        wbs_adr_o   = '0;
        wbs_dat_o   = '0;
        wbs_dat64_o = '0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m0_rty_o    = 1'b0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        m1_rty_o    = 1'b0;
        case (state_q)
            GNT0: begin
                wbs_cyc_o   = m0_cyc_i & ~tmo_hit;
                wbs_stb_o   = m0_stb_i & ~tmo_hit;
                wbs_we_o    = m0_we_i;
                wbs_cab_o   = m0_cab_i;
                wbs_sel_o   = m0_sel_i;
                wbs_adr_o   = m0_adr_i;
                wbs_dat_o   = m0_dat_i;
                wbs_dat64_o = m0_dat64_i;
                m0_ack_o    = wbs_ack_i;
                m0_err_o    = wbs_err_i | tmo_hit;
                m0_rty_o    = wbs_rty_i;
            end
            GNT1: begin
                wbs_cyc_o   = m1_cyc_i & ~tmo_hit;
                wbs_stb_o   = m1_stb_i & ~tmo_hit;
                wbs_we_o    = m1_we_i;
                wbs_cab_o   = m1_cab_i;
                wbs_sel_o   = m1_sel_i;
                wbs_adr_o   = m1_adr_i;
                wbs_dat_o   = m1_dat_i;
                wbs_dat64_o = m1_dat64_i;
                m1_ack_o    = wbs_ack_i;
                m1_err_o    = wbs_err_i | tmo_hit;
                m1_rty_o    = wbs_rty_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast unregistered; only the ack tells who owns it.
    assign m0_dat_o   = wbs_dat_i;
    assign m0_dat64_o = wbs_dat64_i;
    assign m1_dat_o   = wbs_dat_i;
    assign m1_dat64_o = wbs_dat64_i;

    assign arb_gnt_o  = state_q;

endmodule

// File: tb/tb_ss_wbm_arb.sv
// Bench for ss_wbm_arb: arbitration table, directed multi-cycle sequences
// and randomized traffic against a behavioural owner/last-winner model.
module tb_ss_wbm_arb;
    localparam int TMO_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       cyc, stb, we, cab;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] adr, dat, dat64;
    logic [1:0]       ack_o, err_o, rty_o;
    logic [1:0][31:0] rdat, rdat64;
    logic             s_cyc, s_stb, s_we, s_cab;
    logic [3:0]       s_sel;
    logic [31:0]      s_adr, s_dat, s_dat64, sd, sd64;
    logic             s_ack, s_err, s_rty, ack_drv, auto_ack;
    logic [1:0]       gnt;

    // Auto slave acks every strobed cycle; otherwise the bench drives ack.
    assign s_ack = auto_ack ? (s_cyc & s_stb) : ack_drv;

    ss_wbm_arb #(.TMO_W(TMO_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_cab_i(cab[0]),
        .m0_sel_i(sel[0]), .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat64_i(dat64[0]),
        .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]),
        .m0_dat_o(rdat[0]), .m0_dat64_o(rdat64[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_cab_i(cab[1]),
        .m1_sel_i(sel[1]), .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat64_i(dat64[1]),
        .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]),
        .m1_dat_o(rdat[1]), .m1_dat64_o(rdat64[1]),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we), .wbs_cab_o(s_cab),
        .wbs_sel_o(s_sel), .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_dat64_o(s_dat64),
        .wbs_dat_i(sd), .wbs_dat64_i(sd64),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .arb_gnt_o(gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear();
        rst_n = 1'b1; cyc = '0; stb = '0; we = '0; cab = '0;
        sel = '0; adr = '0; dat = '0; dat64 = '0;
        sd = '0; sd64 = '0; ack_drv = 1'b0; s_err = 1'b0; s_rty = 1'b0; auto_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edge_();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] pre;   // 0: none, 1: m0 owned first, 2: m1 owned first
        logic       c0;
        logic       c1;
        logic [1:0] exp;
    } vec_t;
    vec_t tbl[8];

    // Behavioural model: current owner (0 none, 1 m0, 2 m1), last winner, watchdog.
    int         own, last, tmo, n;
    logic [1:0] blk, req, e_ack, e_err, e_rty, e_gnt;
    logic       hit, e_cyc, e_stb, e_we, e_cab;
    logic [3:0] e_sel;
    logic [31:0] e_adr, e_dat, e_dat64;
    int         new_own;

    initial begin
        int n0, n1, t_err, nerr, bad;
        clear();

        // ---------------- arbitration table ----------------
        tbl[0] = '{2'd0, 1'b1, 1'b0, 2'b01};
        tbl[1] = '{2'd0, 1'b0, 1'b1, 2'b10};
        tbl[2] = '{2'd0, 1'b1, 1'b1, 2'b01};
        tbl[3] = '{2'd1, 1'b1, 1'b1, 2'b10};
        tbl[4] = '{2'd2, 1'b1, 1'b1, 2'b01};
        tbl[5] = '{2'd0, 1'b0, 1'b0, 2'b00};
        tbl[6] = '{2'd1, 1'b1, 1'b0, 2'b01};
        tbl[7] = '{2'd2, 1'b0, 1'b1, 2'b10};
        for (int i = 0; i < 8; i++) begin
            clear();
            do_reset();
            auto_ack = 1'b1;
            if (tbl[i].pre != 0) begin
                cyc[tbl[i].pre - 1] = 1'b1;
                edge_();
                cyc[tbl[i].pre - 1] = 1'b0;
                edge_();
            end
            cyc = {tbl[i].c1, tbl[i].c0};
            stb = cyc;
            mid();
            chk($sformatf("tbl%0d_pre_idle", i), gnt, 2'b00);
            edge_();
            mid();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp);
        end

        // ---------------- 1: 4-beat read by m0 ----------------
        clear();
        do_reset();
        mid();
        chk("t1_reset_gnt", gnt, 2'b00);
        chk("t1_reset_out", {s_cyc, s_stb, s_we, s_cab, s_sel, ack_o, err_o, rty_o}, 0);
        auto_ack = 1'b1;
        edge_();
        cyc[0] = 1'b1; stb[0] = 1'b1; cab[0] = 1'b1; adr[0] = 32'h100;
        mid();
        chk("t1_lat0_cyc", s_cyc, 1'b0);
        edge_();
        mid();
        chk("t1_cyc", s_cyc, 1'b1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_adr", s_adr, 32'h100);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin edge_(); mid(); end
            n0 += int'(ack_o[0]);
            n1 += int'(ack_o[1]);
            if (n0 == 4) break;
        end
        edge_();
        cyc[0] = 1'b0; stb[0] = 1'b0; cab[0] = 1'b0;
        chk("t1_m0_acks", n0, 4);
        chk("t1_m1_acks", n1, 0);
        edge_();
        mid();
        chk("t1_idle", gnt, 2'b00);

        // ---------------- 2: simultaneous request, direct handoff ----------------
        clear();
        do_reset();
        auto_ack = 1'b1;
        cyc = 2'b11; stb = 2'b11;
        edge_();
        mid();
        chk("t2_first", gnt, 2'b01);
        edge_();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        mid();
        chk("t2_hold", gnt, 2'b01);
        edge_();
        mid();
        chk("t2_handoff", gnt, 2'b10);
        chk("t2_cyc", s_cyc, 1'b1);

        // ---------------- 3: alternating single-beat transfers ----------------
        clear();
        do_reset();
        auto_ack = 1'b1;
        cyc = 2'b11; stb = 2'b11;
        edge_();
        for (int g = 0; g < 6; g++) begin
            mid();
            chk($sformatf("t3_gnt%0d", g), gnt, (g % 2) ? 2'b10 : 2'b01);
            chk($sformatf("t3_ack%0d", g), ack_o, (g % 2) ? 2'b10 : 2'b01);
            edge_();
            cyc[g % 2] = 1'b0; stb[g % 2] = 1'b0;
            edge_();
            cyc[g % 2] = 1'b1; stb[g % 2] = 1'b1;
        end

        // ---------------- 4: reset in the middle of an m1 burst ----------------
        clear();
        do_reset();
        auto_ack = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; cab[1] = 1'b1; adr[1] = 32'h200;
        edge_();
        n1 = 0;
        for (int k = 0; k < 2; k++) begin
            mid();
            n1 += int'(ack_o[1]);
            edge_();
        end
        chk("t4_two_acks", n1, 2);
        auto_ack = 1'b0;
        rst_n = 1'b0;
        edge_();
        rst_n = 1'b1;
        ack_drv = 1'b1;
        mid();
        chk("t4_cyc_drop", s_cyc, 1'b0);
        chk("t4_gnt_drop", gnt, 2'b00);
        chk("t4_no_ack", ack_o, 2'b00);
        ack_drv = 1'b0;

        // ---------------- 5/6: slave never answers ----------------
        clear();
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h400;
        edge_();
`ifdef ARB_TIMEOUT_EN
        t_err = -1; nerr = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            mid();
            if (err_o[0]) begin
                nerr++;
                if (t_err < 0) t_err = k;
                if (s_cyc || s_stb) bad++;
            end
            if (err_o[1]) bad++;
            if (t_err >= 0 && k > t_err && gnt != 2'b00) bad++;
            edge_();
        end
        chk("t5_err_time", t_err, 15);
        chk("t5_err_once", nerr, 1);
        chk("t5_after", bad, 0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        edge_();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        edge_();
        mid();
        chk("t5_regrant", gnt, 2'b01);
`else
        nerr = 0; bad = 0;
        for (int k = 0; k < 100; k++) begin
            mid();
            if (gnt != 2'b01) bad++;
            nerr += int'(err_o[0]) + int'(err_o[1]);
            edge_();
        end
        chk("t6_gnt_held", bad, 0);
        chk("t6_no_err", nerr, 0);
`endif

        // ---------------- randomized traffic vs. model ----------------
        clear();
        do_reset();
        own = 0; last = 1; tmo = 0; blk = '0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 2; i++) begin
                cyc[i]   = cyc[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                stb[i]   = ($urandom_range(0, 3) != 0);
                we[i]    = $urandom_range(0, 1);
                cab[i]   = $urandom_range(0, 1);
                sel[i]   = 4'($urandom);
                adr[i]   = $urandom;
                dat[i]   = $urandom;
                dat64[i] = $urandom;
            end
            ack_drv = $urandom_range(0, 1);
            s_err   = ($urandom_range(0, 15) == 0);
            s_rty   = ($urandom_range(0, 15) == 0);
            sd      = $urandom;
            sd64    = $urandom;
            mid();

            hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
            hit = (own != 0) && (tmo == (1 << TMO_W) - 1);
`endif
            e_gnt = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
            {e_cyc, e_stb, e_we, e_cab, e_sel, e_adr, e_dat, e_dat64} = '0;
            e_ack = '0; e_err = '0; e_rty = '0;
            if (own != 0) begin
                n = own - 1;
                e_cyc = cyc[n] & ~hit;  e_stb = stb[n] & ~hit;
                e_we = we[n];  e_cab = cab[n];  e_sel = sel[n];
                e_adr = adr[n]; e_dat = dat[n]; e_dat64 = dat64[n];
                e_ack[n] = s_ack; e_err[n] = s_err | hit; e_rty[n] = s_rty;
            end
            chk("rand_ctl", {gnt, ack_o, err_o, rty_o, s_cyc, s_stb, s_we, s_cab, s_sel},
                {e_gnt, e_ack, e_err, e_rty, e_cyc, e_stb, e_we, e_cab, e_sel});
            chk("rand_adr", s_adr, e_adr);
            chk("rand_wdat", {s_dat, s_dat64}, {e_dat, e_dat64});
            chk("rand_rdat0", {rdat[0], rdat64[0]}, {sd, sd64});
            chk("rand_rdat1", {rdat[1], rdat64[1]}, {sd, sd64});

            @(posedge clk);
            if (!rst_n) begin
                own = 0; last = 1; tmo = 0; blk = '0;
            end else begin
                req = cyc & ~blk;
                new_own = own;
                if (own == 0) begin
                    if (req == 2'b11)  new_own = (last == 1) ? 1 : 2;
                    else if (req[0])   new_own = 1;
                    else if (req[1])   new_own = 2;
                end else if (hit) begin
                    new_own = 0;
                    last = own - 1;
                end else if (!cyc[own - 1]) begin
                    last = own - 1;
                    new_own = req[2 - own] ? (3 - own) : 0;
                end
                if (new_own != own || own == 0)  tmo = 0;
                else if (s_ack || s_err || s_rty) tmo = 0;
                else if (stb[own - 1])           tmo = tmo + 1;
                for (int i = 0; i < 2; i++) begin
                    if (hit && own == i + 1) blk[i] = 1'b1;
                    else if (!cyc[i])        blk[i] = 1'b0;
                end
                own = new_own;
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
